// File: rtl/sp_ram_param.sv
// Single-port byte-writable RAM with selectable read-during-write behaviour,
// optional output pipeline register and an optional zero-fill sequence after reset.
module sp_ram_param #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 13,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     ad,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy
);

    localparam int NB         = DATA_W / 8;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int MODE_WT    = 1;
    localparam int MODE_RBW   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   cp_r;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];
    logic [DATA_W-1:0]   q1_r;
    logic                v1_r;

    logic                accept_s;
    logic                clear_we_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [NB-1:0]       wr_be_s;

    // Word seen after a byte-masked write: new bytes where be is set, old bytes elsewhere.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     mask
    );
        logic [DATA_W-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

    assign busy       = (state_r == ST_CLEAR);
    assign accept_s   = ce & ~busy & ~reset;
    assign clear_we_s = (state_r == ST_CLEAR) & ~reset;

    // Clear sequencer: reset (re)starts the sweep from address 0; cp wraps to 0 when it ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cp_r    <= '0;
        end else if (state_r == ST_CLEAR) begin
            cp_r <= cp_r + 1'b1;
            if (cp_r == {ADDR_W{1'b1}}) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= ST_CLEAR;
            end
        end else begin
            state_r <= state_r;
            cp_r    <= cp_r;
        end
    end

    // Single write port shared by the clear sweep and user writes, keeping the array RAM-inferable.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ad;
        wr_data_s = din;
        wr_be_s   = be;
        if (clear_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cp_r;
            wr_data_s = '0;
            wr_be_s   = '1;
        end else if (accept_s && wre) begin
            wr_en_s   = 1'b1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Array write with per-byte enables; no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_s[i]) begin
                    mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // Stage 1: synchronous read; write behaviour chosen by READ_MODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            q1_r <= '0;
            v1_r <= 1'b0;
        end else if (accept_s && !wre) begin
            q1_r <= mem_r[ad];
            v1_r <= 1'b1;
        end else if (accept_s && (READ_MODE == MODE_WT)) begin
            q1_r <= merge_bytes(mem_r[ad], din, be);
            v1_r <= 1'b1;
        end else if (accept_s && (READ_MODE == MODE_RBW)) begin
            q1_r <= mem_r[ad];
            v1_r <= 1'b1;
        end else begin
            q1_r <= q1_r;
            v1_r <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q2_r;
            logic              v2_r;

            // Stage 2: loads only when oce is high; valid needs both oce and a fresh stage-1 word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q2_r <= '0;
                    v2_r <= 1'b0;
                end else begin
                    q2_r <= oce ? q1_r : q2_r;
                    v2_r <= oce & v1_r;
                end
            end

            assign dout       = q2_r;
            assign dout_valid = v2_r;
        end else begin : g_out_bypass
            logic oce_unused_s;
            assign oce_unused_s = oce;
            assign dout         = q1_r;
            assign dout_valid   = v1_r;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_param.sv
// Self-checking bench for sp_ram_param: vector table for the read modes plus
// hand-written sequences for clear, gating, output register and default depth.
module tb_sp_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce, oce, wre, ce4;
    logic [1:0]  be;
    logic [3:0]  ad;
    logic [15:0] din;
    logic        dreset, dce, dwre;
    logic [1:0]  dbe;
    logic [12:0] dad;
    logic [15:0] ddin;

    logic [15:0] dout0, dout1, dout2, dout3, dout4, dout5;
    logic        dv0, dv1, dv2, dv3, dv4, dv5;
    logic        busy0, busy1, busy2, busy3, busy4, busy5;

    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
        .dout(dout0), .dout_valid(dv0), .busy(busy0));
    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
        .dout(dout1), .dout_valid(dv1), .busy(busy1));
    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
        .dout(dout2), .dout_valid(dv2), .busy(busy2));
    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u3 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
        .dout(dout3), .dout_valid(dv3), .busy(busy3));
    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u4 (
        .clk(clk), .reset(reset), .ce(ce4), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
        .dout(dout4), .dout_valid(dv4), .busy(busy4));
    sp_ram_param u5 (
        .clk(clk), .reset(dreset), .ce(dce), .oce(1'b1), .wre(dwre), .be(dbe), .ad(dad), .din(ddin),
        .dout(dout5), .dout_valid(dv5), .busy(busy5));

    typedef struct {
        int          due;
        int          inst;
        logic [15:0] d;
        logic        v;
        string       tag;
    } exp_t;

    typedef struct {
        logic        c;
        logic        w;
        logic [1:0]  b;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] e0; logic v0;
        logic [15:0] e1; logic v1;
        logic [15:0] e2; logic v2;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [16:0] outof(input int k);
        case (k)
            0: return {dv0, dout0};
            1: return {dv1, dout1};
            2: return {dv2, dout2};
            3: return {dv3, dout3};
            4: return {dv4, dout4};
            5: return {dv5, dout5};
            default: return 17'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic push(input int lat, input int inst, input logic [15:0] d, input logic v, input string tag);
        sb.push_back('{cyc + lat, inst, d, v, tag});
    endtask

    // Advance one clock and compare every scoreboard entry that falls due now.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [16:0] got;
                got = outof(sb[i].inst);
                n_cmp++;
                if (got !== {sb[i].v, sb[i].d}) begin
                    n_bad++;
                    $display("FAIL %s (u%0d): got dout=%h valid=%b, want dout=%h valid=%b",
                             sb[i].tag, sb[i].inst, got[15:0], got[16], sb[i].d, sb[i].v);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        reset = r; ce = c; wre = w; be = b; ad = a; din = d;
    endtask

    initial begin
        int n;
        reset = 1'b1; ce = 1'b0; oce = 1'b1; wre = 1'b0; be = 2'b00; ad = 4'd0; din = 16'h0; ce4 = 1'b0;
        dreset = 1'b1; dce = 1'b0; dwre = 1'b0; dbe = 2'b11; dad = 13'd0; ddin = 16'h0;

        //            c     w     be     ad     din       u0 (mode 0)      u1 (write-through) u2 (read-before-write)
        tbl[0]  = '{1'b1, 1'b1, 2'b11, 4'd3,  16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b1, 16'h0000, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 2'b01, 4'd3,  16'h1234, 16'h0000, 1'b0, 16'hAB34, 1'b1, 16'hABCD, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 4'd3,  16'h0000, 16'hAB34, 1'b1, 16'hAB34, 1'b1, 16'hAB34, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 2'b11, 4'd5,  16'h1111, 16'hAB34, 1'b0, 16'h1111, 1'b1, 16'h0000, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 2'b11, 4'd5,  16'h2222, 16'hAB34, 1'b0, 16'h2222, 1'b1, 16'h1111, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 16'hAB34, 1'b0, 16'h2222, 1'b0, 16'h1111, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 4'd5,  16'h0000, 16'h2222, 1'b1, 16'h2222, 1'b1, 16'h2222, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 4'd7,  16'hFFFF, 16'h2222, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 4'd7,  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 4'd15, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 2'b10, 4'd15, 16'hBEEF, 16'h0000, 1'b0, 16'hBE00, 1'b1, 16'h0000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 4'd15, 16'h0000, 16'hBE00, 1'b1, 16'hBE00, 1'b1, 16'hBE00, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 4'd0,  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};

        // Reset state and first clear sweep.
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        chk("rst_busy", busy0, 1'b1);
        chk("rst_dout", dout0, 16'h0000);
        chk("rst_valid", dv0, 1'b0);
        chk("rst_dout_oreg", {dv3, dout3}, 17'h0);
        chk("noclear_busy", busy4, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
            chk("clear_busy", busy0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        chk("clear_done", busy0, 1'b0);
        chk("clear_done_oreg", busy3, 1'b0);

        // Reset again, re-assert at cycle 8; a write attempted late in the sweep must be ignored.
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        end
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        for (int i = 1; i <= 15; i++) begin
            if (i == 14) step(1'b0, 1'b1, 1'b1, 2'b11, 4'd6, 16'hDEAD);
            else         step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
            tick();
            chk("restart_busy", busy0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); tick();
        chk("restart_done", busy0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'b00, i[3:0], 16'h0);
            push(1, 0, 16'h0000, 1'b1, $sformatf("clear_read_%0d", i));
            tick();
        end

        for (int k = 0; k < 13; k++) begin
            step(1'b0, tbl[k].c, tbl[k].w, tbl[k].b, tbl[k].a, tbl[k].d);
            push(1, 0, tbl[k].e0, tbl[k].v0, $sformatf("tbl%0d_m0", k));
            push(1, 1, tbl[k].e1, tbl[k].v1, $sformatf("tbl%0d_m1", k));
            push(1, 2, tbl[k].e2, tbl[k].v2, $sformatf("tbl%0d_m2", k));
            tick();
        end

        // Output register: latency 2 with oce=1, hold and no valid with oce=0.
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0); oce = 1'b1;
        push(2, 3, 16'hAB34, 1'b1, "oreg_read"); tick();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); oce = 1'b1; tick();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); oce = 1'b1;
        push(1, 3, 16'hAB34, 1'b0, "oreg_one_pulse"); tick();
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0); oce = 1'b1;
        push(2, 3, 16'h2222, 1'b1, "oreg_read5"); tick();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); oce = 1'b1; tick();
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0); oce = 1'b0;
        push(1, 3, 16'h2222, 1'b0, "oreg_hold_a");
        push(2, 3, 16'h2222, 1'b0, "oreg_hold_b"); tick();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); oce = 1'b0; tick();
        oce = 1'b1;

        // No-clear instance: contents survive reset; a write on the reset edge is dropped.
        step(1'b0, 1'b0, 1'b1, 2'b11, 4'd2, 16'h5555); ce4 = 1'b1; tick();
        step(1'b1, 1'b0, 1'b1, 2'b11, 4'd2, 16'h9999); ce4 = 1'b1; tick();
        chk("u4_rst_out", {dv4, dout4}, 17'h0);
        chk("u4_rst_busy", busy4, 1'b0);
        chk("reset_clears_q1", {dv0, dout0}, 17'h0);
        chk("reset_clears_q2", {dv3, dout3}, 17'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 16'h0); ce4 = 1'b1;
        push(1, 4, 16'h5555, 1'b1, "u4_write_dropped"); tick();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0); ce4 = 1'b0; tick();

        // Default geometry: full 8192-cycle clear, then the top address.
        @(negedge clk); dreset = 1'b0;
        n = 0;
        while (busy5 === 1'b1 && n < 10000) begin
            n++;
            tick();
        end
        chk("dflt_clear_len", n, 8192);
        @(negedge clk); dce = 1'b1; dwre = 1'b1; dad = 13'h1FFF; ddin = 16'hC0DE; tick();
        @(negedge clk); dad = 13'h0000; ddin = 16'h7777; tick();
        @(negedge clk); dwre = 1'b0; dad = 13'h1FFF;
        push(1, 5, 16'hC0DE, 1'b1, "dflt_top_addr"); tick();
        @(negedge clk); dad = 13'h0001;
        push(1, 5, 16'h0000, 1'b1, "dflt_cleared"); tick();
        @(negedge clk); dad = 13'h0000;
        push(1, 5, 16'h7777, 1'b1, "dflt_addr0"); tick();
        @(negedge clk); dce = 1'b0; tick();
        tick();

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
